// File: rtl/rx_block_sync.sv
// 64B/66B receive block synchronizer: hunts for sync-header alignment via gearbox
// slips, tracks block lock with windowed bad-header counting, registers the RX stream.
module rx_block_sync #(
  parameter int unsigned LOCK_CNT  = 64,
  parameter int unsigned BAD_WIN   = 64,
  parameter int unsigned BAD_MAX   = 16,
  parameter int unsigned SLIP_WAIT = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] i_rx_data,
  input  logic        i_rx_valid,
  input  logic [1:0]  i_rx_header,
  input  logic        i_rx_header_valid,
  output logic        o_rx_slipbit,
  output logic        o_block_lock,
  output logic [63:0] o_rx_data,
  output logic [1:0]  o_rx_header,
  output logic        o_rx_valid,
  output logic        o_rx_header_valid,
  output logic [15:0] o_bad_cnt
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned WW = $clog2(BAD_WIN + 1);
  localparam int unsigned BW = $clog2(BAD_MAX + 1);
  localparam int unsigned TW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_END   = WW'(BAD_WIN);
  localparam logic [BW-1:0] BAD_LIMIT = BW'(BAD_MAX);
  localparam logic [TW-1:0] WAIT_LAST = TW'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {HUNT, SLIP, WAIT, LOCK} state_e;

  state_e      state_q, state_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [BW-1:0] bad_win_q, bad_win_d;
  logic [15:0]   bad_cnt_q, bad_cnt_d;
  logic [63:0]   data_q, data_d;
  logic [1:0]    header_q, header_d;
  logic          valid_q, valid_d;
  logic          hvalid_q, hvalid_d;

  logic          hdr_good;
  logic [WW-1:0] win_inc;
  logic [BW-1:0] bad_inc;

  assign hdr_good = i_rx_header[1] ^ i_rx_header[0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= HUNT;
      good_cnt_q <= '0;
      wait_cnt_q <= '0;
      win_cnt_q  <= '0;
      bad_win_q  <= '0;
      bad_cnt_q  <= '0;
      data_q     <= '0;
      header_q   <= '0;
      valid_q    <= 1'b0;
      hvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      win_cnt_q  <= win_cnt_d;
      bad_win_q  <= bad_win_d;
      bad_cnt_q  <= bad_cnt_d;
      data_q     <= data_d;
      header_q   <= header_d;
      valid_q    <= valid_d;
      hvalid_q   <= hvalid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    wait_cnt_d = '0;
    win_cnt_d  = win_cnt_q;
    bad_win_d  = bad_win_q;
    bad_cnt_d  = bad_cnt_q;
    win_inc    = win_cnt_q + WW'(1);
    bad_inc    = hdr_good ? bad_win_q : bad_win_q + BW'(1);

    unique case (state_q)
      HUNT: begin
        if (i_rx_header_valid) begin
          if (!hdr_good) begin
            state_d    = SLIP;
            good_cnt_d = '0;
          end else if (good_cnt_q == GOOD_LAST) begin
            state_d    = LOCK;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + GW'(1);
          end
        end
      end
      SLIP: state_d = WAIT;
      WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d    = HUNT;
          good_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      LOCK: begin
        if (i_rx_header_valid) begin
          if (!hdr_good && bad_cnt_q != '1) begin
            bad_cnt_d = bad_cnt_q + 16'd1;
          end
          // Threshold test precedes the window-end test so loss of lock wins a tie.
          if (bad_inc == BAD_LIMIT) begin
            state_d   = SLIP;
            win_cnt_d = '0;
            bad_win_d = '0;
          end else if (win_inc == WIN_END) begin
            win_cnt_d = '0;
            bad_win_d = '0;
          end else begin
            win_cnt_d = win_inc;
            bad_win_d = bad_inc;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    data_d   = i_rx_data;
    header_d = i_rx_header;
    valid_d  = i_rx_valid & (state_q == LOCK);
    hvalid_d = i_rx_header_valid & (state_q == LOCK);
  end

  always_comb begin
    o_rx_slipbit      = (state_q == SLIP);
    o_block_lock      = (state_q == LOCK);
    o_rx_data         = data_q;
    o_rx_header       = header_q;
    o_rx_valid        = valid_q;
    o_rx_header_valid = hvalid_q;
    o_bad_cnt         = bad_cnt_q;
  end

endmodule

// File: tb/tb_rx_block_sync.sv
// Bench for rx_block_sync: directed scenarios plus a randomized run against a
// behavioural model of the Clause 49 hunt/slip/lock rules.
module tb_rx_block_sync;

  localparam int LOCK_CNT  = 64;
  localparam int BAD_WIN   = 64;
  localparam int BAD_MAX   = 16;
  localparam int SLIP_WAIT = 32;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [63:0] i_rx_data;
  logic        i_rx_valid;
  logic [1:0]  i_rx_header;
  logic        i_rx_header_valid;
  logic        o_rx_slipbit;
  logic        o_block_lock;
  logic [63:0] o_rx_data;
  logic [1:0]  o_rx_header;
  logic        o_rx_valid;
  logic        o_rx_header_valid;
  logic [15:0] o_bad_cnt;

  always #5 i_clk = ~i_clk;

  rx_block_sync #(
    .LOCK_CNT (LOCK_CNT),
    .BAD_WIN  (BAD_WIN),
    .BAD_MAX  (BAD_MAX),
    .SLIP_WAIT(SLIP_WAIT)
  ) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_rx_data        (i_rx_data),
    .i_rx_valid       (i_rx_valid),
    .i_rx_header      (i_rx_header),
    .i_rx_header_valid(i_rx_header_valid),
    .o_rx_slipbit     (o_rx_slipbit),
    .o_block_lock     (o_block_lock),
    .o_rx_data        (o_rx_data),
    .o_rx_header      (o_rx_header),
    .o_rx_valid       (o_rx_valid),
    .o_rx_header_valid(o_rx_header_valid),
    .o_bad_cnt        (o_bad_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: lock flag, pending slip, wait countdown and run/window tallies.
  bit          m_locked, m_slip, m_valid, m_hvalid;
  int          m_wait, m_good, m_win, m_winbad, m_bad_total;
  logic [63:0] m_data;
  logic [1:0]  m_hdr;

  function automatic void model_reset();
    m_locked = 0; m_slip = 0; m_valid = 0; m_hvalid = 0;
    m_wait = 0; m_good = 0; m_win = 0; m_winbad = 0; m_bad_total = 0;
    m_data = '0; m_hdr = '0;
  endfunction

  function automatic void model_step(input logic [63:0] d, input logic v,
                                     input logic [1:0] h, input logic hv);
    bit was_locked;
    bit bad;
    was_locked = m_locked;
    bad        = !(h == 2'b01 || h == 2'b10);
    m_data   = d;
    m_hdr    = h;
    m_valid  = v && was_locked;
    m_hvalid = hv && was_locked;
    if (m_slip) begin
      m_slip = 0;
      m_wait = SLIP_WAIT;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) m_good = 0;
    end else if (m_locked) begin
      if (hv) begin
        m_win++;
        if (bad) begin
          m_winbad++;
          if (m_bad_total < 65535) m_bad_total++;
        end
        if (m_winbad == BAD_MAX) begin
          m_locked = 0; m_slip = 1; m_win = 0; m_winbad = 0;
        end else if (m_win == BAD_WIN) begin
          m_win = 0; m_winbad = 0;
        end
      end
    end else if (hv) begin
      if (bad) begin
        m_slip = 1; m_good = 0;
      end else begin
        m_good++;
        if (m_good == LOCK_CNT) begin
          m_locked = 1; m_good = 0;
        end
      end
    end
  endfunction

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic drive(input logic [63:0] d, input logic v,
                       input logic [1:0] h, input logic hv);
    i_rx_data = d; i_rx_valid = v; i_rx_header = h; i_rx_header_valid = hv;
    @(posedge i_clk);
    model_step(d, v, h, hv);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    for (int unsigned c = 0; c < 4; c++) begin
      i_rx_data = rnd64(); i_rx_valid = 1'($urandom);
      i_rx_header = 2'($urandom); i_rx_header_valid = 1'($urandom);
      @(posedge i_clk);
      #1;
      n_vec++;
      if ({o_rx_slipbit, o_block_lock, o_rx_data, o_rx_header, o_rx_valid,
           o_rx_header_valid, o_bad_cnt} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: got lock=%b slip=%b data=%h hdr=%b v=%b hv=%b bad=%0d required all 0",
                 o_block_lock, o_rx_slipbit, o_rx_data, o_rx_header, o_rx_valid,
                 o_rx_header_valid, o_bad_cnt);
      end
    end
    i_rst = 1'b0;
    model_reset();
    for (int unsigned i = 0; i < 10; i++) begin
      drive(rnd64(), 1'b1, good_hdr(), 1'b1);
      n_vec++;
      if ({o_block_lock, o_rx_slipbit} !== 2'b00) begin
        n_err++;
        $display("FAIL reset_10_good: got lock=%b slip=%b required 0 0", o_block_lock, o_rx_slipbit);
      end
    end
  endtask

  task automatic test_acquire();
    logic [63:0] d;
    logic        v, hv;
    logic [1:0]  h;
    do_reset();
    for (int unsigned i = 0; i < 64; i++) begin
      v = 1'($urandom);
      drive(rnd64(), v, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1);
      n_vec++;
      if (o_block_lock !== (i == 63) || o_rx_slipbit !== 1'b0 || o_rx_valid !== 1'b0) begin
        n_err++;
        $display("FAIL acquire_hdr%0d: got lock=%b slip=%b valid=%b required lock=%b slip=0 valid=0",
                 i, o_block_lock, o_rx_slipbit, o_rx_valid, (i == 63));
      end
    end
    for (int unsigned i = 0; i < 16; i++) begin
      d = rnd64(); v = 1'($urandom); h = good_hdr(); hv = 1'($urandom);
      drive(d, v, h, hv);
      n_vec++;
      if ({o_block_lock, o_rx_data, o_rx_header, o_rx_valid, o_rx_header_valid} !==
          {1'b1, d, h, v, hv}) begin
        n_err++;
        $display("FAIL acquire_stream: got lock=%b data=%h hdr=%b v=%b hv=%b required 1 %h %b %b %b",
                 o_block_lock, o_rx_data, o_rx_header, o_rx_valid, o_rx_header_valid, d, h, v, hv);
      end
    end
  endtask

  task automatic test_slip_wait();
    do_reset();
    for (int unsigned i = 0; i < 63; i++) drive(rnd64(), 1'b1, good_hdr(), 1'b1);
    drive(rnd64(), 1'b1, bad_hdr(), 1'b1);
    n_vec++;
    if ({o_rx_slipbit, o_block_lock} !== 2'b10) begin
      n_err++;
      $display("FAIL first_slip: got slip=%b lock=%b required 1 0", o_rx_slipbit, o_block_lock);
    end
    // One header lands in the slip cycle itself, then SLIP_WAIT in the wait period.
    for (int unsigned i = 0; i < 33; i++) begin
      drive(rnd64(), 1'b1, bad_hdr(), 1'b1);
      n_vec++;
      if ({o_rx_slipbit, o_block_lock} !== 2'b00) begin
        n_err++;
        $display("FAIL wait_ignores_bad%0d: got slip=%b lock=%b required 0 0", i, o_rx_slipbit, o_block_lock);
      end
    end
    drive(rnd64(), 1'b1, bad_hdr(), 1'b1);
    n_vec++;
    if (o_rx_slipbit !== 1'b1) begin
      n_err++;
      $display("FAIL second_slip: got slip=%b required 1", o_rx_slipbit);
    end
  endtask

  task automatic test_unlock();
    logic [63:0] pat;
    int          cnt, seen;
    do_reset();
    for (int unsigned i = 0; i < 64; i++) drive(rnd64(), 1'b1, good_hdr(), 1'b1);
    n_vec++;
    if (o_block_lock !== 1'b1) begin
      n_err++;
      $display("FAIL unlock_setup_lock: got %b required 1", o_block_lock);
    end
    pat = '0; cnt = 0;
    while (cnt < 15) begin
      int j = $urandom_range(0, 63);
      if (!pat[j]) begin pat[j] = 1'b1; cnt++; end
    end
    for (int unsigned i = 0; i < 64; i++) begin
      drive(rnd64(), 1'b1, pat[i] ? bad_hdr() : good_hdr(), 1'b1);
      n_vec++;
      if ({o_block_lock, o_rx_slipbit} !== 2'b10) begin
        n_err++;
        $display("FAIL window15_hdr%0d: got lock=%b slip=%b required 1 0", i, o_block_lock, o_rx_slipbit);
      end
    end
    n_vec++;
    if (o_bad_cnt !== 16'd15) begin
      n_err++;
      $display("FAIL window15_bad_cnt: got %0d required 15", o_bad_cnt);
    end
    pat = '0; cnt = 0;
    while (cnt < 16) begin
      int j = $urandom_range(0, 63);
      if (!pat[j]) begin pat[j] = 1'b1; cnt++; end
    end
    seen = 0;
    for (int unsigned i = 0; i < 64 && seen < 16; i++) begin
      drive(rnd64(), 1'b1, pat[i] ? bad_hdr() : good_hdr(), 1'b1);
      if (pat[i]) seen++;
      n_vec++;
      if ({o_block_lock, o_rx_slipbit} !== ((seen == 16) ? 2'b01 : 2'b10)) begin
        n_err++;
        $display("FAIL window16_hdr%0d: got lock=%b slip=%b required lock=%b slip=%b",
                 i, o_block_lock, o_rx_slipbit, (seen != 16), (seen == 16));
      end
    end
    n_vec++;
    if (o_bad_cnt !== 16'd31) begin
      n_err++;
      $display("FAIL window16_bad_cnt: got %0d required 31", o_bad_cnt);
    end
    drive(rnd64(), 1'b1, good_hdr(), 1'b1);
    n_vec++;
    if ({o_rx_slipbit, o_bad_cnt} !== {1'b0, 16'd31}) begin
      n_err++;
      $display("FAIL unlock_after: got slip=%b bad=%0d required 0 31", o_rx_slipbit, o_bad_cnt);
    end
  endtask

  task automatic test_qualifier_gaps();
    int good_seen = 0;
    int guard = 0;
    do_reset();
    while (good_seen < 64 && guard < 400) begin
      guard++;
      if ($urandom_range(0, 2) == 0) begin
        drive(rnd64(), 1'($urandom), 2'b11, 1'b0);
      end else begin
        drive(rnd64(), 1'($urandom), good_hdr(), 1'b1);
        good_seen++;
      end
      n_vec++;
      if ({o_block_lock, o_rx_slipbit} !== {(good_seen == 64), 1'b0}) begin
        n_err++;
        $display("FAIL gaps_good%0d: got lock=%b slip=%b required %b 0",
                 good_seen, o_block_lock, o_rx_slipbit, (good_seen == 64));
      end
    end
    n_vec++;
    if (good_seen != 64) begin
      n_err++;
      $display("FAIL gaps_budget: got %0d good headers required 64", good_seen);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    drive(rnd64(), 1'b1, good_hdr(), 1'b1);
    drive(rnd64(), 1'b1, bad_hdr(), 1'b1);
    drive(rnd64(), 1'b1, good_hdr(), 1'b1);
    for (int unsigned i = 0; i < 5; i++) drive(64'hA5A5_0000_0000_0001 | rnd64(), 1'b1, 2'b11, 1'b1);
    #3;
    i_rst = 1'b1;
    #1;
    n_vec++;
    if ({o_rx_slipbit, o_block_lock, o_rx_data, o_rx_header, o_rx_valid,
         o_rx_header_valid, o_bad_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_wait: got lock=%b slip=%b data=%h hdr=%b bad=%0d required all 0",
               o_block_lock, o_rx_slipbit, o_rx_data, o_rx_header, o_bad_cnt);
    end
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    model_reset();
    for (int unsigned i = 0; i < 64; i++) begin
      drive(rnd64(), 1'b1, good_hdr(), 1'b1);
      n_vec++;
      if ({o_block_lock, o_rx_slipbit} !== {(i == 63), 1'b0}) begin
        n_err++;
        $display("FAIL relock_hdr%0d: got lock=%b slip=%b required %b 0",
                 i, o_block_lock, o_rx_slipbit, (i == 63));
      end
    end
  endtask

  task automatic test_random();
    int unsigned rates[8] = '{0, 5, 0, 15, 0, 25, 0, 50};
    logic [1:0]  h;
    do_reset();
    for (int unsigned p = 0; p < 8; p++) begin
      for (int unsigned c = 0; c < 200; c++) begin
        h = ($urandom_range(0, 99) < rates[p]) ? bad_hdr() : good_hdr();
        drive(rnd64(), 1'($urandom), h, ($urandom_range(0, 9) != 0));
        n_vec++;
        if ({o_block_lock, o_rx_slipbit} !== {m_locked, m_slip}) begin
          n_err++;
          $display("FAIL random_fsm p%0d c%0d: got lock=%b slip=%b required %b %b",
                   p, c, o_block_lock, o_rx_slipbit, m_locked, m_slip);
        end
        n_vec++;
        if ({o_rx_data, o_rx_header, o_rx_valid, o_rx_header_valid} !==
            {m_data, m_hdr, m_valid, m_hvalid}) begin
          n_err++;
          $display("FAIL random_data p%0d c%0d: got %h %b %b %b required %h %b %b %b",
                   p, c, o_rx_data, o_rx_header, o_rx_valid, o_rx_header_valid,
                   m_data, m_hdr, m_valid, m_hvalid);
        end
        n_vec++;
        if (o_bad_cnt !== 16'(m_bad_total)) begin
          n_err++;
          $display("FAIL random_bad_cnt p%0d c%0d: got %0d required %0d", p, c, o_bad_cnt, m_bad_total);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst = 1'b1;
    i_rx_data = '0; i_rx_valid = 1'b0; i_rx_header = '0; i_rx_header_valid = 1'b0;
    model_reset();
    test_reset();
    test_acquire();
    test_slip_wait();
    test_unlock();
    test_qualifier_gaps();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rx_block_sync.md
# rx_block_sync

Receive-side 64B/66B block synchronizer that sits directly downstream of one GT channel's RX gearbox output. It checks every sync header the gearbox produces, drives the gearbox slip request until header alignment is found, and declares block lock using the IEEE 802.3 Clause 49 lock/unlock rules. The RX data stream is forwarded to the PCS with a 1-cycle register, and valid is qualified by lock. One instance is used per GT channel.

## Interface
- LOCK_CNT, 64: consecutive good headers required to gain lock.
- BAD_WIN, 64: header window length while locked.
- BAD_MAX, 16: bad headers within one window that drop lock.
- SLIP_WAIT, 32: cycles to ignore headers after each slip, while the gearbox re-aligns.

- i_clk  in  1  RX user clock; the channel's o_rx_clk.
- i_rst  in  1  asynchronous, active-high reset.
- i_rx_data  in  64  gearbox payload.
- i_rx_valid  in  1  payload valid.
- i_rx_header  in  2  sync header.
- i_rx_header_valid  in  1  header qualifier. Headers are evaluated only when this is high.
- o_rx_slipbit  out  1  one-cycle slip request; drives the channel's i_rx_slipbit.
- o_block_lock  out  1  block lock status.
- o_rx_data  out  64  registered payload.
- o_rx_header  out  2  registered header.
- o_rx_valid  out  1  registered i_rx_valid AND locked.
- o_rx_header_valid  out  1  registered i_rx_header_valid AND locked.
- o_bad_cnt  out  16  saturating count of bad headers seen while locked.

## Operation
- A header is good when it is 2'b01 or 2'b10. A header is bad when it is 2'b00 or 2'b11.
- The FSM has four states: HUNT, SLIP, WAIT, LOCK. The reset state is HUNT.
- HUNT:
  - Counter good_cnt (7 bits) increments on each good header.
  - A bad header goes to SLIP and clears good_cnt.
  - When the good header that makes good_cnt reach LOCK_CNT is sampled, go to LOCK.
- SLIP: lasts one cycle. o_rx_slipbit=1. Then go to WAIT.
- WAIT:
  - wait_cnt counts SLIP_WAIT clock cycles, regardless of i_rx_header_valid.
  - Headers are ignored.
  - Then go to HUNT with good_cnt=0.
- LOCK:
  - win_cnt counts headers (good or bad).
  - bad_win counts bad headers.
  - If bad_win reaches BAD_MAX, go to SLIP and clear both counters.
  - Otherwise, when win_cnt reaches BAD_WIN, clear both counters and stay in LOCK.
  - If the window end and bad_win reaching BAD_MAX happen on the same header, losing lock wins.
- o_block_lock = (state==LOCK), registered.
- o_bad_cnt increments on each bad header in LOCK and saturates at 16'hFFFF. Only reset clears it.
- Data path: every cycle, o_rx_data <= i_rx_data and o_rx_header <= i_rx_header, unconditionally.
- o_rx_valid and o_rx_header_valid are gated by the lock state before the current edge.
- Reset values: all outputs 0. All counters 0. State HUNT.
- Reset asserted mid-operation in any state returns immediately to these values.

## Timing
- Data latency is 1 cycle.
- o_block_lock rises 1 cycle after the edge that samples the LOCK_CNT-th good header.
- o_rx_slipbit is high exactly 1 cycle. It starts the cycle after the edge that samples the triggering bad header.
- Slip-to-slip minimum spacing is 1 + SLIP_WAIT + 1 cycles. HUNT needs at least one header sample before it can slip again.
- o_block_lock falls in the same cycle that o_rx_slipbit rises on loss of lock.
- A cycle with i_rx_header_valid=0 changes no counter except wait_cnt.

## Test plan
- Reset: assert i_rst with random inputs -> all outputs 0. After release, feed 10 good headers -> o_block_lock stays 0 and o_rx_slipbit stays 0.
- Acquire: feed 64 alternating 01/10 headers, all valid -> o_block_lock=1 one cycle after the 64th. o_rx_valid follows i_rx_valid from then on, delayed 1 cycle.
- Slip and wait: feed 63 good then 1 bad -> o_rx_slipbit high 1 cycle, no lock. Feed 32 bad headers during WAIT -> no further slip. Then one bad header -> second slip pulse.
- Unlock threshold: lock, then 15 bad among 64 headers -> lock held, o_bad_cnt=15. Next window with 16 bad -> lock drops on the 16th bad, slip pulse the same cycle, o_bad_cnt=31.
- Qualifier gaps: in HUNT, 2'b11 with i_rx_header_valid=0 interleaved among 64 good valid headers -> lock acquired, no slip.
- Reset mid-WAIT: assert i_rst 5 cycles into WAIT -> outputs 0 immediately. After release, the FSM is in HUNT and needs 64 fresh good headers to lock.
